// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and operand/result bundle for the serial magnitude comparator.
// The requester drives start/operands; the comparator drives status and result.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic             o_gt;
  logic             o_eq;
  logic             o_lt;

  modport master (
    output start, signed_mode, x, y,
    input  busy, done, o_gt, o_eq, o_lt
  );

  modport slave (
    input  start, signed_mode, x, y,
    output busy, done, o_gt, o_eq, o_lt
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first multi-cycle magnitude comparator, DIGIT bits per clock, with
// signed/unsigned mode, optional early termination and start/busy/done handshake.
module serial_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_magnitude_comparator_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [KW-1:0]    k_q, k_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             done_q, done_d;
  logic             res_gt_q, res_gt_d;
  logic             res_eq_q, res_eq_d;
  logic             res_lt_q, res_lt_d;

  logic [DIGIT-1:0] xd, yd;
  logic             acc_gt, acc_eq, last;

  // Operands shift left each RUN cycle, so the current digit is always the top one.
  assign xd     = xs_q[WIDTH-1 -: DIGIT];
  assign yd     = ys_q[WIDTH-1 -: DIGIT];
  assign acc_gt = eq_q ? (xd > yd) : gt_q;
  assign acc_eq = eq_q & (xd == yd);
  assign last   = (k_q == KW'(N - 1)) || ((EARLY_EXIT != 0) && !acc_eq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    xs_d     = xs_q;
    ys_d     = ys_q;
    k_d      = k_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    done_d   = 1'b0;
    res_gt_d = res_gt_q;
    res_eq_d = res_eq_q;
    res_lt_d = res_lt_q;
    if (state_q == IDLE) begin
      if (bus.start) begin
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        xs_d = bus.x ^ (bus.signed_mode ? MSB : '0);
        ys_d = bus.y ^ (bus.signed_mode ? MSB : '0);
        k_d  = '0;
        gt_d = 1'b0;
        eq_d = 1'b1;
      end
    end else begin
      xs_d = xs_q << DIGIT;
      ys_d = ys_q << DIGIT;
      k_d  = k_q + KW'(1);
      gt_d = acc_gt;
      eq_d = acc_eq;
      if (last) begin
        done_d   = 1'b1;
        res_gt_d = acc_gt;
        res_eq_d = acc_eq;
        res_lt_d = !acc_gt && !acc_eq;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q     <= '0;
      ys_q     <= '0;
      k_q      <= '0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      done_q   <= 1'b0;
      res_gt_q <= 1'b0;
      res_eq_q <= 1'b0;
      res_lt_q <= 1'b0;
    end else begin
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      k_q      <= k_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      done_q   <= done_d;
      res_gt_q <= res_gt_d;
      res_eq_q <= res_eq_d;
      res_lt_q <= res_lt_d;
    end
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = done_q;
    bus.o_gt = res_gt_q;
    bus.o_eq = res_eq_q;
    bus.o_lt = res_lt_q;
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and back-to-back checks of the serial magnitude comparator in
// three configurations: bit-serial early-exit, nibble full-length, single-cycle.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator_if #(.WIDTH(8)) ia ();
  serial_magnitude_comparator_if #(.WIDTH(8)) ib ();
  serial_magnitude_comparator_if #(.WIDTH(8)) ic ();

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ia));
  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(4), .EARLY_EXIT(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ib));
  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(8), .EARLY_EXIT(1)) dut_c (
    .clk(clk), .rst(rst), .bus(ic));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic st, input logic sm,
                       input logic [7:0] xv, input logic [7:0] yv);
    case (id)
      0: begin ia.start = st; ia.signed_mode = sm; ia.x = xv; ia.y = yv; end
      1: begin ib.start = st; ib.signed_mode = sm; ib.x = xv; ib.y = yv; end
      default: begin ic.start = st; ic.signed_mode = sm; ic.x = xv; ic.y = yv; end
    endcase
  endtask

  function automatic logic done_of(input int id);
    case (id)
      0: return ia.done;
      1: return ib.done;
      default: return ic.done;
    endcase
  endfunction

  function automatic logic [4:0] status_of(input int id);
    case (id)
      0: return {ia.busy, ia.done, ia.o_gt, ia.o_eq, ia.o_lt};
      1: return {ib.busy, ib.done, ib.o_gt, ib.o_eq, ib.o_lt};
      default: return {ic.busy, ic.done, ic.o_gt, ic.o_eq, ic.o_lt};
    endcase
  endfunction

  function automatic logic [2:0] ref_cmp(input logic sm, input logic [7:0] a, input logic [7:0] b);
    if (a == b) return 3'b010;
    if (sm) return ($signed(a) > $signed(b)) ? 3'b100 : 3'b001;
    return (a > b) ? 3'b100 : 3'b001;
  endfunction

  // Launch one compare from IDLE; lat = edges after the start edge until done (-1 on timeout).
  task automatic go(input int id, input logic sm, input logic [7:0] xv, input logic [7:0] yv,
                    output int lat, output logic [2:0] res);
    logic [4:0] s;
    drive(id, 1'b1, sm, xv, yv);
    tick();
    drive(id, 1'b0, sm, xv, yv);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_of(id)) begin
        lat = i;
        break;
      end
    end
    s   = status_of(id);
    res = s[2:0];
  endtask

  task automatic test_reset();
    for (int id = 0; id < 3; id++) begin
      n_cmp++;
      if (status_of(id) !== 5'b0)
        begin n_err++; $display("FAIL reset_state[%0d]: got %b want 00000", id, status_of(id)); end
    end
  endtask

  task automatic test_equal();
    int lat; logic [2:0] res;
    go(0, 1'b0, 8'hA5, 8'hA5, lat, res);
    n_cmp++;
    if (lat !== 8) begin n_err++; $display("FAIL eq_latency: got %0d want 8", lat); end
    n_cmp++;
    if (res !== 3'b010) begin n_err++; $display("FAIL eq_result: got %b want 010", res); end
  endtask

  task automatic test_signed();
    int lat; logic [2:0] res;
    go(0, 1'b0, 8'h80, 8'h7F, lat, res);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL unsigned_latency: got %0d want 1", lat); end
    n_cmp++;
    if (res !== 3'b100) begin n_err++; $display("FAIL unsigned_80_7f: got %b want 100", res); end
    go(0, 1'b1, 8'h80, 8'h7F, lat, res);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL signed_latency: got %0d want 1", lat); end
    n_cmp++;
    if (res !== 3'b001) begin n_err++; $display("FAIL signed_80_7f: got %b want 001", res); end
    go(0, 1'b1, 8'hFE, 8'hFF, lat, res);
    n_cmp++;
    if (res !== 3'b001) begin n_err++; $display("FAIL signed_m2_m1: got %b want 001", res); end
  endtask

  task automatic test_digit4();
    int lat; logic [2:0] res;
    go(1, 1'b0, 8'h3C, 8'h3D, lat, res);
    n_cmp++;
    if (lat !== 2) begin n_err++; $display("FAIL d4_lt_latency: got %0d want 2", lat); end
    n_cmp++;
    if (res !== 3'b001) begin n_err++; $display("FAIL d4_3c_3d: got %b want 001", res); end
    go(1, 1'b0, 8'h4C, 8'h3D, lat, res);
    n_cmp++;
    if (lat !== 2) begin n_err++; $display("FAIL d4_gt_latency: got %0d want 2", lat); end
    n_cmp++;
    if (res !== 3'b100) begin n_err++; $display("FAIL d4_4c_3d: got %b want 100", res); end
  endtask

  task automatic test_single_cycle();
    int lat; logic [2:0] res;
    go(2, 1'b1, 8'h80, 8'h7F, lat, res);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL n1_latency: got %0d want 1", lat); end
    n_cmp++;
    if (res !== 3'b001) begin n_err++; $display("FAIL n1_signed: got %b want 001", res); end
    go(2, 1'b0, 8'h55, 8'h55, lat, res);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL n1_eq_latency: got %0d want 1", lat); end
    n_cmp++;
    if (res !== 3'b010) begin n_err++; $display("FAIL n1_eq: got %b want 010", res); end
  endtask

  task automatic test_ignored_start();
    int ndone = 0;
    drive(0, 1'b1, 1'b0, 8'h10, 8'h20);
    tick();
    drive(0, 1'b0, 1'b0, 8'h10, 8'h20);
    tick();
    drive(0, 1'b1, 1'b0, 8'hFF, 8'h00);
    tick();
    drive(0, 1'b0, 1'b1, 8'h7F, 8'hC3);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ia.done) ndone++;
    end
    n_cmp++;
    if (ndone !== 1) begin n_err++; $display("FAIL ignored_start_pulses: got %0d want 1", ndone); end
    n_cmp++;
    if ({ia.o_gt, ia.o_eq, ia.o_lt} !== 3'b001)
      begin n_err++; $display("FAIL ignored_start_result: got %b want 001", {ia.o_gt, ia.o_eq, ia.o_lt}); end
    n_cmp++;
    if (ia.busy !== 1'b0) begin n_err++; $display("FAIL ignored_start_idle: got %b want 0", ia.busy); end
  endtask

  task automatic test_reset_midrun();
    int ndone = 0; int lat; logic [2:0] res;
    drive(0, 1'b1, 1'b0, 8'hA5, 8'hA5);
    tick();
    drive(0, 1'b0, 1'b0, 8'hA5, 8'hA5);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (status_of(0) !== 5'b0) begin n_err++; $display("FAIL async_reset: got %b want 00000", status_of(0)); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ia.done || ia.busy) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin n_err++; $display("FAIL no_done_after_reset: got %0d want 0", ndone); end
    go(0, 1'b0, 8'h01, 8'h01, lat, res);
    n_cmp++;
    if (res !== 3'b010) begin n_err++; $display("FAIL post_reset_eq: got %b want 010", res); end
    n_cmp++;
    if (lat !== 8) begin n_err++; $display("FAIL post_reset_latency: got %0d want 8", lat); end
    // Reset and start together: reset wins.
    drive(0, 1'b1, 1'b0, 8'h80, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h80, 8'h00);
    tick();
    n_cmp++;
    if (status_of(0) !== 5'b0) begin n_err++; $display("FAIL reset_beats_start: got %b want 00000", status_of(0)); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_q[$];
    logic [2:0] exp_r;
    logic [7:0] xv, yv;
    logic       sm, cap;
    int pushed = 0;
    int popped = 0;
    for (int cyc = 0; cyc < 30000 && popped < 1000; cyc++) begin
      xv = 8'($urandom);
      yv = ($urandom_range(0, 7) == 0) ? xv : 8'($urandom);
      sm = 1'($urandom_range(0, 1));
      drive(0, (pushed < 1000), sm, xv, yv);
      cap = ia.start && !ia.busy;
      if (cap) begin
        exp_q.push_back(ref_cmp(sm, xv, yv));
        pushed++;
      end
      tick();
      if (cap) begin
        n_cmp++;
        if (ia.busy !== 1'b1) begin n_err++; $display("FAIL b2b_start_accept[%0d]: busy %b want 1", pushed, ia.busy); end
      end
      if (ia.done) begin
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        popped++;
        n_cmp++;
        if ({ia.o_gt, ia.o_eq, ia.o_lt} !== exp_r)
          begin n_err++; $display("FAIL b2b_result[%0d]: got %b want %b", popped, {ia.o_gt, ia.o_eq, ia.o_lt}, exp_r); end
      end
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    n_cmp++;
    if (popped !== 1000) begin n_err++; $display("FAIL b2b_count: got %0d want 1000", popped); end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_equal();
    test_signed();
    test_digit4();
    test_single_cycle();
    test_ignored_start();
    test_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
